// File: rtl/split_track_pkg.sv
// split_track_pkg: request/response field layout shared by the interconnect
// blocks. A request is {valid, addr, wdata, wstrb}, MSB first.
// A response is {rdata, ready}, MSB first.
package split_track_pkg;

    // Width of the write-strobe field: one strobe bit per data byte.
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

    // Width of the packed request {valid, addr, wdata, wstrb}.
    function automatic int req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + strb_w(data_w);
    endfunction

    // Width of the packed response {rdata, ready}.
    function automatic int resp_w(input int data_w);
        return data_w + 1;
    endfunction

    // Width of the optional watchdog counter.
    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/split_track.sv
// split_track: one-master to N-slave split-transaction router.
// IDLE decodes the slave from the top address bits and forwards the request
// combinationally. If the slave stalls, the block moves to BUSY and locks
// onto that slave until it answers.
// Out-of-range slave selects produce a one-cycle error response.
// Optional watchdog: define SPLIT_TRACK_TIMEOUT_EN to enable it. The block
// then abandons a BUSY transaction after TIMEOUT_CYC stalled cycles.
module split_track
    import split_track_pkg::*;
#(
    parameter int N_SLAVES    = 2,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int P_SLAVES    = $clog2(N_SLAVES),
    parameter int TIMEOUT_CYC = 255,
    localparam int REQ_W      = req_w(ADDR_W, DATA_W),
    localparam int RESP_W     = resp_w(DATA_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_W-1:0]           m_req,
    output logic [RESP_W-1:0]          m_resp,
    output logic [N_SLAVES*REQ_W-1:0]  s_req,
    input  logic [N_SLAVES*RESP_W-1:0] s_resp,
    output logic                       err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Elaboration-time guard on parameter legality.
    if (N_SLAVES < 2 || N_SLAVES > 16) begin : g_bad_n_slaves
        $error("split_track: N_SLAVES must be within 2..16");
    end
    if (TIMEOUT_CYC < 8 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("split_track: TIMEOUT_CYC must be within 8..65535");
    end

    // Slave select is the top P_SLAVES address bits.
    function automatic logic [P_SLAVES-1:0] decode_sel(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: P_SLAVES];
    endfunction

    state_e                state_q, state_d;
    logic [P_SLAVES-1:0]   sel_q, sel_d;
    logic                  dec_err_q, dec_err_d;

    logic                  m_valid;
    logic [P_SLAVES-1:0]   sel_dec;
    logic                  dec_bad;
    logic                  busy_ready;
    logic                  timeout_hit;
    logic                  route_en;
    logic [P_SLAVES-1:0]   route_sel;

    logic [REQ_W-1:0]      s_req_arr  [N_SLAVES];
    logic [RESP_W-1:0]     s_resp_arr [N_SLAVES];

    // Unpack / pack the flattened slave buses, one slot per slave.
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slot
        assign s_resp_arr[gi]              = s_resp[gi*RESP_W +: RESP_W];
        assign s_req[gi*REQ_W +: REQ_W]    = s_req_arr[gi];
    end

    assign m_valid    = m_req[REQ_W-1];
    assign sel_dec    = decode_sel(m_req[REQ_W-2 -: ADDR_W]);
    assign dec_bad    = int'(sel_dec) >= N_SLAVES;
    // sel_q is only out of range while dec_err_q is set, and that path never uses busy_ready.
    assign busy_ready = s_resp_arr[sel_q][0];

`ifdef SPLIT_TRACK_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout_hit = (state_q == ST_BUSY) && !dec_err_q
                         && (tmo_cnt_q == TMO_CNT_W'(TIMEOUT_CYC));

    // Watchdog: held at zero in IDLE, counts stalled BUSY cycles.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = '0;
        end else if (!busy_ready && !timeout_hit) begin
            tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
        end
    end

    // Watchdog register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Output routing: forward to one slave and return its response, or synthesise an error response.
    always_comb begin
        for (int i = 0; i < N_SLAVES; i++) begin
            s_req_arr[i] = '0;
        end
        m_resp    = '0;
        err       = 1'b0;
        route_en  = 1'b0;
        route_sel = sel_q;
        if (!rst) begin
            if (state_q == ST_IDLE) begin
                if (m_valid && !dec_bad) begin
                    route_en  = 1'b1;
                    route_sel = sel_dec;
                end
            end else if (dec_err_q) begin
                m_resp = RESP_W'(1);            // rdata = 0, ready = 1
                err    = 1'b1;
            end else if (timeout_hit) begin
                m_resp = '1;                    // rdata = all ones, ready = 1
                err    = 1'b1;
            end else begin
                route_en  = 1'b1;               // locked to sel_q, address ignored
                route_sel = sel_q;
            end
        end
        if (route_en) begin
            s_req_arr[route_sel] = m_req;
            m_resp               = s_resp_arr[route_sel];
        end
    end

    // Next-state logic for the IDLE/BUSY tracker.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        dec_err_d = dec_err_q;
        case (state_q)
            ST_IDLE: begin
                if (m_valid) begin
                    sel_d = sel_dec;
                    if (dec_bad) begin
                        state_d   = ST_BUSY;
                        dec_err_d = 1'b1;
                    end else if (!s_resp_arr[sel_dec][0]) begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (dec_err_q) begin
                    state_d   = ST_IDLE;
                    dec_err_d = 1'b0;
                end else if (timeout_hit || busy_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, locked slave select and decode-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            dec_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            dec_err_q <= dec_err_d;
        end
    end

endmodule

// File: doc/split_track.md
SPLIT_TRACK -- requirements
Module: split_track

Interface
REQ-001 Parameter N_SLAVES, default 2: number of downstream slave ports; legal range 2..16.
REQ-002 Parameter DATA_W, default 32: data width in bits.
REQ-003 Parameter ADDR_W, default 32: address width in bits.
REQ-004 Parameter P_SLAVES, default $clog2(N_SLAVES): slave-select field width, taken from addr[ADDR_W-1 -: P_SLAVES].
REQ-005 Parameter TIMEOUT_CYC, default 255: watchdog limit in cycles, 8..65535; used only when SPLIT_TRACK_TIMEOUT_EN is defined.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 m_req  input  REQ_W  master request {valid, addr, wdata, wstrb}, using the shared interconnect field layout.
REQ-009 m_resp  output  RESP_W  master response {rdata, ready}.
REQ-010 s_req  output  N_SLAVES*REQ_W  slave requests, flattened; slave i occupies slot i.
REQ-011 s_resp  input  N_SLAVES*RESP_W  slave responses, flattened; slave i occupies slot i.
REQ-012 err  output  1  one-cycle pulse when a transaction completes with a decode error or a timeout.

Function
REQ-013 The block shall implement a two-state FSM: IDLE and BUSY.
REQ-014 In IDLE with m valid=1, the block shall decode sel from the address and forward m_req to s_req[sel] combinationally in the same cycle.
REQ-015 In IDLE with m valid=1, the block shall register sel into sel_q.
REQ-016 From IDLE, the FSM shall move to BUSY at the next edge if the selected slave's ready is 0 in that cycle; otherwise it shall stay in IDLE.
REQ-017 In BUSY, the block shall route m_req only to s_req[sel_q] and return s_resp[sel_q] on m_resp, regardless of the current address bits.
REQ-018 In BUSY, the FSM shall return to IDLE at the edge where the selected slave's ready=1.
REQ-019 The master holds valid until ready; a valid drop in BUSY is a protocol violation, and the block shall remain in BUSY until ready or timeout.
REQ-020 All non-selected s_req slots shall be driven all-zero at all times.
REQ-021 m_resp shall be all-zero whenever no transaction is active.
REQ-022 A decoded sel >= N_SLAVES shall cause a decode error:
  - no slave valid is asserted;
  - the FSM enters BUSY with a decode-error flag set;
  - the next cycle returns m ready=1, rdata=0, err=1;
  - the FSM then returns to IDLE.
REQ-023 Back-to-back transactions shall be accepted: a valid held in the cycle after ready shall start a new IDLE decode with zero added latency.
REQ-024 Zero-wait-state slaves (ready in the same cycle as valid) shall complete in one cycle without entering BUSY.

Reset
REQ-025 While rst=1, the block shall:
  - force the state to IDLE;
  - clear sel_q, the timeout counter and the decode-error flag;
  - drive s_req and m_resp all-zero;
  - drive err=0.
REQ-026 A reset asserted mid-transaction shall abandon the transaction with no response to the master; the first post-reset cycle is IDLE.

Configuration
REQ-027 With SPLIT_TRACK_TIMEOUT_EN defined, a 16-bit counter shall:
  - clear on entry to BUSY;
  - increment each BUSY cycle without ready;
  - on reaching TIMEOUT_CYC, drive m ready=1, rdata={DATA_W{1'b1}} and err=1 for one cycle, deassert s_req[sel_q] valid, and return to IDLE.
REQ-028 Without SPLIT_TRACK_TIMEOUT_EN, no counter shall be instantiated, and BUSY shall wait indefinitely for ready.

Structure
REQ-029 REQ_W, RESP_W and the valid/addr/wdata/wstrb/rdata/ready field macros shall come from the shared interconnect header; the state encodings (IDLE=0, BUSY=1) shall be localparams of this module.
REQ-030 The implementation shall be a single flat module with no sub-modules; the address decoder shall be an inline function.

Verification
REQ-031 N_SLAVES=2, write addr=0x8000_0010, slave1 ready in the same cycle -> s_req slot1 valid=1 in that cycle, slot0 all-zero, m ready=1, FSM stays IDLE.
REQ-032 Read addr=0x0000_0004, slave0 returns ready at cycle 3 with rdata=0x1234_5678 -> BUSY during cycles 1-2, m_resp={0x1234_5678, 1} at cycle 3, IDLE at cycle 4.
REQ-033 N_SLAVES=3, P_SLAVES=2, addr=0xC000_0000 -> no s_req valid, m ready=1 with rdata=0 and err=1 exactly one cycle later.
REQ-034 Address MSB toggled from 0 to 1 while BUSY on slave0 -> slave1 valid stays 0, and the response still comes from slave0.
REQ-035 SPLIT_TRACK_TIMEOUT_EN defined, TIMEOUT_CYC=8, slave never ready -> at the timeout cycle: m ready=1, rdata=0xFFFF_FFFF, err=1; FSM is IDLE the next cycle.
REQ-036 rst=1 asserted during BUSY -> at the next edge all s_req=0 and m_resp=0; a new request after reset routes correctly.
